ram_load_arbiter: RTL and testbench
===================================

Name: ram_load_arbiter

Overview:
- Packs three 16-bit host streams (data, weight, bias) into BURST_LEN-halfword BRAM lines.
- Arbitrates the packed lines round-robin onto one shared BRAM write port, with a per-target select and address.
- Sits between the okClk-side pipe-in endpoints and the d/w/b BRAMs. It replaces the per-stream ad-hoc packers and counters.
- Tracks per-stream line counts against host-programmed targets and raises done flags.

Parameters:
- BURST_LEN, 8, halfwords per BRAM line (line width = 16*BURST_LEN).
- AW, 13, width of shared write address (wide enough for weight BRAM, 8192 lines).
- D_DEPTH, 1024, data BRAM lines; address wraps at this.
- W_DEPTH, 8192, weight BRAM lines.
- B_DEPTH, 1024, bias BRAM lines.

Ports:
- clk  in  1  sole clock (okClk domain)
- rst  in  1  asynchronous, active-low reset
- in_valid  in  3  per-stream halfword valid; bit0 data, bit1 weight, bit2 bias
- in_data  in  48  per-stream halfword; stream s at [16s+15:16s]
- in_ready  out  3  per-stream accept; a transfer happens when valid&ready
- clr  in  3  synchronous per-stream clear pulse
- cfg_lines  in  3*AW  per-stream target line count, sampled on clr
- wr_en  out  1  BRAM write strobe
- wr_sel  out  2  target: 0 data, 1 weight, 2 bias; 3 never driven
- wr_addr  out  AW  line address within target
- wr_data  out  16*BURST_LEN  packed line; first-accepted halfword in bits [15:0]
- done  out  3  stream has written cfg_lines lines
- busy  out  1  any line pending or any packer non-empty

Behaviour:
- Reset (rst=0, async): all outputs 0, except in_ready=3'b111. Packer counts, pending flags, address counters and line counters cleared. RR pointer=0. Targets=0.
- Per-stream packer: shift register; accepted halfword enters at the top, previous contents shift down 16 bits. Count runs 0..BURST_LEN-1.
- Line completion: accepting at count==BURST_LEN-1 sets pending[s], latches the line into line_buf[s], and resets count to 0.
- Backpressure: in_ready[s] = ~pending[s] (registered view). While pending, the stream stalls.
- Arbiter: each cycle, grant the first pending stream at or after the RR pointer (order 0,1,2, wrapping).
  - On grant g: pointer <= (g+1) mod 3 and pending[g] cleared.
  - Next cycle (registered, latency 1): wr_en=1, wr_sel=g, wr_addr=addr[g], wr_data=line_buf[g].
  - At most one grant per cycle.
  - With no pending line, wr_en=0 and the other outputs hold their last values.
- Address counter addr[s] increments after each grant to s. It wraps to 0 after D_DEPTH-1, W_DEPTH-1 or B_DEPTH-1 respectively.
- Line counter lines[s] increments per grant and saturates at its maximum. done[s]=1 when lines[s]==target[s] and target[s]!=0; done stays 1 until clr.
- Simultaneous grant of s and completion of a new line on s: not possible, because in_ready[s]=0 while pending[s].
- Throughput: pending clears in the grant cycle, so in_ready[s] returns 1 the following cycle. Minimum line period per stream = BURST_LEN+1 cycles.
- clr[s] (sync): count, pending, addr, lines and done for s are zeroed; target[s] <= cfg_lines[s]. A partial line is discarded. Other streams are unaffected.
  - clr[s] in the same cycle as a grant to s: the write still issues next cycle with the pre-clear address, then addr becomes 0.
  - clr has priority over an accept in the same cycle; the halfword is dropped.
- Reset mid-operation: any in-flight write is abandoned and wr_en forced 0 immediately.
- busy = |pending | (any count!=0) | wr_en.

Test Plan:
- Reset then a single stream: after reset, in_ready=3'b111 and wr_en=0. Push 8 halfwords 0x0001..0x0008 on data. Next cycle wr_en=1, wr_sel=0, wr_addr=0, wr_data=0x0008_0007_..._0001. Second line goes to wr_addr=1.
- Round-robin: complete lines on all three streams in the same cycle. Writes issue on three consecutive cycles with wr_sel 0, 1, 2. Repeat with the pointer at 1: order becomes 1, 2, 0.
- Backpressure: hold a weight line pending while data and bias lines keep completing. in_ready[1]=0 until weight is granted; no halfword is lost or duplicated (compare against a scoreboard).
- Wrap: clr bias with cfg_lines=3, then write 1026 bias lines. Addresses run 0..1023 then 0, 1. done[2] rises after the 3rd write and stays high.
- clr mid-line: push 5 halfwords on data, pulse clr[0], then push 8 new ones. A single write issues at wr_addr=0 containing only the new 8 halfwords.
- Async reset during a pending grant: drop rst in the grant cycle. wr_en is never asserted, and busy=0 and in_ready=3'b111 after release.

Source files
------------

// File: rtl/ram_load_arbiter.sv
// Packs three 16-bit host streams into BURST_LEN-halfword lines and arbitrates
// them round-robin onto one shared BRAM write port with per-stream line tracking.
module ram_load_arbiter #(
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned AW        = 13,
  parameter int unsigned D_DEPTH   = 1024,
  parameter int unsigned W_DEPTH   = 8192,
  parameter int unsigned B_DEPTH   = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0]             in_valid,
  input  logic [47:0]            in_data,
  output logic [2:0]             in_ready,
  input  logic [2:0]             clr,
  input  logic [3*AW-1:0]        cfg_lines,
  output logic                   wr_en,
  output logic [1:0]             wr_sel,
  output logic [AW-1:0]          wr_addr,
  output logic [16*BURST_LEN-1:0] wr_data,
  output logic [2:0]             done,
  output logic                   busy
);

  localparam int unsigned NS = 3;
  localparam int unsigned LW = 16 * BURST_LEN;
  localparam int unsigned SW = LW - 16;
  localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [CW-1:0] count_q [NS];
  logic [CW-1:0] count_d [NS];
  logic [SW-1:0] shreg_q [NS];
  logic [SW-1:0] shreg_d [NS];
  logic [LW-1:0] line_q  [NS];
  logic [LW-1:0] line_d  [NS];
  logic [AW-1:0] addr_q  [NS];
  logic [AW-1:0] addr_d  [NS];
  logic [AW-1:0] lines_q [NS];
  logic [AW-1:0] lines_d [NS];
  logic [AW-1:0] target_q[NS];
  logic [AW-1:0] target_d[NS];
  logic [NS-1:0] pending_q, pending_d;
  logic [NS-1:0] done_d, ready_d;
  logic [1:0]    ptr_q, ptr_d;
  logic          grant_vld;
  logic [1:0]    grant;
  logic          wr_en_d;
  logic [1:0]    wr_sel_d;
  logic [AW-1:0] wr_addr_d;
  logic [LW-1:0] wr_data_d;
  logic          busy_d;

  function automatic logic [AW-1:0] last_addr(input int s);
    case (s)
      0:       return AW'(D_DEPTH - 1);
      1:       return AW'(W_DEPTH - 1);
      default: return AW'(B_DEPTH - 1);
    endcase
  endfunction

  // Next-state: arbitration, packers, address/line counters and output staging
  always_comb begin
    logic          acc;
    logic          granted;
    logic [LW-1:0] full;

    count_d   = count_q;
    shreg_d   = shreg_q;
    line_d    = line_q;
    addr_d    = addr_q;
    lines_d   = lines_q;
    target_d  = target_q;
    pending_d = pending_q;
    done_d    = done;
    ptr_d     = ptr_q;
    grant_vld = 1'b0;
    grant     = 2'd0;
    wr_en_d   = 1'b0;
    wr_sel_d  = wr_sel;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    acc       = 1'b0;
    granted   = 1'b0;
    full      = '0;

    // First pending stream at or after the pointer, wrapping 0,1,2
    for (int k = 0; k < NS; k++) begin
      for (int s = 0; s < NS; s++) begin
        if (!grant_vld && pending_q[s] && 32'(s) == (32'(ptr_q) + 32'(k)) % 32'd3) begin
          grant_vld = 1'b1;
          grant     = 2'(s);
        end
      end
    end

    if (grant_vld) begin
      wr_en_d  = 1'b1;
      wr_sel_d = grant;
      ptr_d    = (grant == 2'd2) ? 2'd0 : grant + 2'd1;
    end

    for (int s = 0; s < NS; s++) begin
      acc     = in_valid[s] & in_ready[s] & ~clr[s];
      granted = grant_vld && (grant == 2'(s));
      full    = {in_data[16*s +: 16], shreg_q[s]};

      if (acc) begin
        shreg_d[s] = full[LW-1:16];
        if (count_q[s] == CW'(BURST_LEN - 1)) begin
          count_d[s]   = '0;
          pending_d[s] = 1'b1;
          line_d[s]    = full;
        end else begin
          count_d[s] = count_q[s] + CW'(1);
        end
      end

      if (granted) begin
        pending_d[s] = 1'b0;
        addr_d[s]    = (addr_q[s] == last_addr(s)) ? '0 : addr_q[s] + AW'(1);
        lines_d[s]   = (&lines_q[s]) ? lines_q[s] : lines_q[s] + AW'(1);
        wr_addr_d    = addr_q[s];
        wr_data_d    = line_q[s];
      end

      if (lines_q[s] == target_q[s] && target_q[s] != '0)
        done_d[s] = 1'b1;

      // Clear discards any partial line and a pending line; an issuing grant still completes
      if (clr[s]) begin
        count_d[s]   = '0;
        pending_d[s] = 1'b0;
        addr_d[s]    = '0;
        lines_d[s]   = '0;
        done_d[s]    = 1'b0;
        target_d[s]  = cfg_lines[AW*s +: AW];
      end

      ready_d[s] = ~pending_d[s];
    end

    busy_d = (|pending_d) | wr_en_d;
    for (int s = 0; s < NS; s++)
      if (count_d[s] != '0) busy_d = 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '{default: '0};
      shreg_q   <= '{default: '0};
      line_q    <= '{default: '0};
      addr_q    <= '{default: '0};
      lines_q   <= '{default: '0};
      target_q  <= '{default: '0};
      pending_q <= '0;
      ptr_q     <= 2'd0;
      in_ready  <= 3'b111;
      wr_en     <= 1'b0;
      wr_sel    <= 2'd0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= '0;
      busy      <= 1'b0;
    end else begin
      count_q   <= count_d;
      shreg_q   <= shreg_d;
      line_q    <= line_d;
      addr_q    <= addr_d;
      lines_q   <= lines_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      ptr_q     <= ptr_d;
      in_ready  <= ready_d;
      wr_en     <= wr_en_d;
      wr_sel    <= wr_sel_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Directed bench for ram_load_arbiter: packing, round-robin order, backpressure,
// address wrap with done, clear mid-line and async reset during a grant.
module tb_ram_load_arbiter;

  localparam int unsigned AW = 13;
  localparam int unsigned LW = 128;

  logic          clk;
  logic          rst;
  logic [2:0]    in_valid;
  logic [47:0]   in_data;
  logic [2:0]    in_ready;
  logic [2:0]    clr;
  logic [3*AW-1:0] cfg_lines;
  logic          wr_en;
  logic [1:0]    wr_sel;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_data;
  logic [2:0]    done;
  logic          busy;

  int total = 0;
  int bad   = 0;

  logic [1:0]    mq_sel  [$];
  logic [AW-1:0] mq_addr [$];
  logic [LW-1:0] mq_data [$];

  ram_load_arbiter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clr(clr), .cfg_lines(cfg_lines), .wr_en(wr_en),
    .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port log, sampled just after each rising edge
  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      mq_sel.push_back(wr_sel);
      mq_addr.push_back(wr_addr);
      mq_data.push_back(wr_data);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack(input logic [15:0] base);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[16*k +: 16] = base + 16'(k);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic qclear();
    mq_sel.delete();
    mq_addr.delete();
    mq_data.delete();
  endtask

  task automatic push_line(input logic [2:0] mask, input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2);
    for (int k = 0; k < 8; k++) begin
      in_valid = mask;
      in_data  = {b2 + 16'(k), b1 + 16'(k), b0 + 16'(k)};
      tick(1);
    end
    in_valid = 3'b000;
  endtask

  initial begin
    int            sent [3];
    int            nline[3];
    logic [15:0]   sbase[3];
    logic [AW-1:0] eaddr[3];
    logic [2:0]    rdy;
    int            s;
    int            addr_err;

    rst = 1'b0; in_valid = '0; in_data = '0; clr = '0; cfg_lines = '0;
    tick(2);
    chk("rst_ready", 128'(in_ready), 128'(3'b111));
    chk("rst_wr_en", 128'(wr_en), 128'(1'b0));
    rst = 1'b1;
    tick(1);
    chk("idle_busy", 128'(busy), 128'(1'b0));
    chk("idle_done", 128'(done), 128'(3'b000));
    chk("idle_wr_addr", 128'(wr_addr), 128'(13'd0));
    chk("idle_wr_data", wr_data, 128'h0);

    // Single data stream: two lines
    qclear();
    push_line(3'b001, 16'h0001, 16'h0, 16'h0);
    chk("t1_no_write_yet", 128'(wr_en), 128'(1'b0));
    chk("t1_stall", 128'(in_ready), 128'(3'b110));
    chk("t1_busy", 128'(busy), 128'(1'b1));
    tick(1);
    chk("t1_wr_en", 128'(wr_en), 128'(1'b1));
    chk("t1_wr_sel", 128'(wr_sel), 128'(2'd0));
    chk("t1_wr_addr", 128'(wr_addr), 128'(13'd0));
    chk("t1_wr_data", wr_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    tick(1);
    chk("t1_wr_en_low", 128'(wr_en), 128'(1'b0));
    chk("t1_ready_back", 128'(in_ready), 128'(3'b111));
    chk("t1_busy_low", 128'(busy), 128'(1'b0));
    chk("t1_hold_addr", 128'(wr_addr), 128'(13'd0));
    push_line(3'b001, 16'h0011, 16'h0, 16'h0);
    tick(1);
    chk("t1b_wr_addr", 128'(wr_addr), 128'(13'd1));
    chk("t1b_wr_data", wr_data, pack(16'h0011));
    tick(1);
    chk("t1_write_count", 128'(mq_sel.size()), 128'(2));

    // Round-robin with pointer at 1 (last grant was data)
    push_line(3'b111, 16'h1000, 16'h2000, 16'h3000);
    chk("rr1_all_stalled", 128'(in_ready), 128'(3'b000));
    tick(1);
    chk("rr1_sel_a", 128'(wr_sel), 128'(2'd1));
    chk("rr1_addr_a", 128'(wr_addr), 128'(13'd0));
    chk("rr1_data_a", wr_data, pack(16'h2000));
    tick(1);
    chk("rr1_sel_b", 128'(wr_sel), 128'(2'd2));
    chk("rr1_en_b", 128'(wr_en), 128'(1'b1));
    tick(1);
    chk("rr1_sel_c", 128'(wr_sel), 128'(2'd0));
    chk("rr1_addr_c", 128'(wr_addr), 128'(13'd2));
    chk("rr1_data_c", wr_data, pack(16'h1000));
    tick(1);
    chk("rr1_en_off", 128'(wr_en), 128'(1'b0));

    // Bias alone moves the pointer back to 0
    push_line(3'b100, 16'h0, 16'h0, 16'h3100);
    tick(1);
    chk("bias_sel", 128'(wr_sel), 128'(2'd2));
    chk("bias_addr", 128'(wr_addr), 128'(13'd1));
    tick(1);

    push_line(3'b111, 16'h1100, 16'h2100, 16'h3200);
    tick(1);
    chk("rr2_sel_a", 128'(wr_sel), 128'(2'd0));
    chk("rr2_addr_a", 128'(wr_addr), 128'(13'd3));
    tick(1);
    chk("rr2_sel_b", 128'(wr_sel), 128'(2'd1));
    chk("rr2_addr_b", 128'(wr_addr), 128'(13'd1));
    chk("rr2_data_b", wr_data, pack(16'h2100));
    tick(1);
    chk("rr2_sel_c", 128'(wr_sel), 128'(2'd2));
    chk("rr2_addr_c", 128'(wr_addr), 128'(13'd2));
    tick(1);

    // Streaming backpressure: 4 lines per stream, scoreboarded
    qclear();
    sbase[0] = 16'h4000; sbase[1] = 16'h5000; sbase[2] = 16'h6000;
    eaddr[0] = 13'd4;    eaddr[1] = 13'd2;    eaddr[2] = 13'd3;
    for (int i = 0; i < 3; i++) begin sent[i] = 0; nline[i] = 0; end
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (sent[0] >= 32 && sent[1] >= 32 && sent[2] >= 32) break;
      for (int i = 0; i < 3; i++) begin
        in_valid[i]        = (sent[i] < 32);
        in_data[16*i +: 16] = sbase[i] + 16'(sent[i]);
      end
      rdy = in_ready;
      tick(1);
      for (int i = 0; i < 3; i++) if (in_valid[i] && rdy[i]) sent[i]++;
      if (cyc == 8) chk("bp_weight_stalled", 128'(in_ready), 128'(3'b001));
      if (cyc == 9) chk("bp_weight_released", 128'(in_ready), 128'(3'b011));
    end
    in_valid = '0;
    tick(6);
    chk("bp_write_count", 128'(mq_sel.size()), 128'(12));
    chk("bp_busy", 128'(busy), 128'(1'b0));
    for (int i = 0; i < mq_sel.size(); i++) begin
      s = int'(mq_sel[i]);
      if (s > 2) begin
        chk("bp_sel_range", 128'(mq_sel[i]), 128'(2'd0));
      end else begin
        chk("bp_addr", 128'(mq_addr[i]), 128'(eaddr[s]));
        chk("bp_data", mq_data[i], pack(sbase[s] + 16'(8 * nline[s])));
        eaddr[s] = eaddr[s] + 13'd1;
        nline[s]++;
      end
    end

    // Bias wrap with target 3
    cfg_lines = {13'd3, 13'd0, 13'd0};
    clr = 3'b100;
    tick(1);
    clr = '0; cfg_lines = '0;
    chk("wrap_done_cleared", 128'(done), 128'(3'b000));
    qclear();
    for (int n = 0; n < 1026; n++) begin
      push_line(3'b100, 16'h0, 16'h0, 16'(n));
      tick(2);
      if (n == 1) chk("wrap_done_before", 128'(done), 128'(3'b000));
      if (n == 2) chk("wrap_done_rise", 128'(done), 128'(3'b100));
    end
    chk("wrap_count", 128'(mq_addr.size()), 128'(1026));
    chk("wrap_addr_1023", 128'(mq_addr[1023]), 128'(13'd1023));
    chk("wrap_addr_1024", 128'(mq_addr[1024]), 128'(13'd0));
    chk("wrap_addr_1025", 128'(mq_addr[1025]), 128'(13'd1));
    chk("wrap_sel", 128'(mq_sel[1025]), 128'(2'd2));
    chk("wrap_data", mq_data[1025], pack(16'd1025));
    addr_err = 0;
    for (int i = 0; i < mq_addr.size(); i++) if (mq_addr[i] !== 13'(i % 1024)) addr_err++;
    chk("wrap_addr_seq", 128'(addr_err), 128'(0));
    chk("wrap_done_held", 128'(done), 128'(3'b100));

    // Clear mid-line on data; halfword offered during clr is dropped
    qclear();
    for (int k = 0; k < 5; k++) begin
      in_valid = 3'b001;
      in_data  = {32'h0, 16'h00A0 + 16'(k)};
      tick(1);
    end
    clr = 3'b001; in_valid = 3'b001; in_data = {32'h0, 16'hEEEE};
    tick(1);
    clr = '0; in_valid = '0;
    chk("clr_busy", 128'(busy), 128'(1'b0));
    push_line(3'b001, 16'h00B0, 16'h0, 16'h0);
    tick(1);
    chk("clr_wr_en", 128'(wr_en), 128'(1'b1));
    chk("clr_wr_addr", 128'(wr_addr), 128'(13'd0));
    chk("clr_wr_data", wr_data, pack(16'h00B0));
    tick(3);
    chk("clr_write_count", 128'(mq_sel.size()), 128'(1));

    // Async reset in the grant cycle of a weight line
    qclear();
    push_line(3'b010, 16'h0, 16'h7000, 16'h0);
    rst = 1'b0;
    #1;
    chk("ar_ready_async", 128'(in_ready), 128'(3'b111));
    chk("ar_wr_en_async", 128'(wr_en), 128'(1'b0));
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("ar_wr_en", 128'(wr_en), 128'(1'b0));
    chk("ar_busy", 128'(busy), 128'(1'b0));
    chk("ar_ready", 128'(in_ready), 128'(3'b111));
    chk("ar_done", 128'(done), 128'(3'b000));
    chk("ar_no_writes", 128'(mq_sel.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
